vram_responder: RTL and testbench

VRAM_RESPONDER -- requirements
Module: vram_responder

---
 rtl/video_pkg.sv | 19 +
 rtl/vram_lat_pipe.sv | 30 +++
 rtl/vram_responder.sv | 159 +++++++++++++++
 tb/tb_vram_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared VRAM widths, request-source tags and arbiter FSM states.
package video_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TILE = 2'd1,
        SRC_PAL  = 2'd2,
        SRC_CPU  = 2'd3
    } src_e;

    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_CPU_FORCE = 1'b1
    } vram_state_e;

endpackage

// File: rtl/vram_lat_pipe.sv
// Source-tag delay line matching the external RAM read latency.
module vram_lat_pipe
    import video_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  src_e tag_i,
    output src_e tag_o
);

    src_e stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= SRC_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_responder.sv
// Single-port VRAM arbiter: palette > tile > CPU, with returned read data tagged by source.
// Define VRAM_CPU_PORT_EN to compile in the CPU write path and starvation forcing.
module vram_responder
    import video_pkg::*;
#(
    parameter int MEM_LAT        = 1,
    parameter int CPU_STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tile_req,
    input  logic [VRAM_AW-1:0] tile_RAM_addr,
    output logic               tile_ack,
    output logic [7:0]         tile_ROM_addr,
    output logic               tile_valid,
    input  logic               pal_req,
    input  logic [VRAM_AW-1:0] palette_RAM_addr,
    output logic               pal_ack,
    output logic [5:0]         palette_ROM_addr,
    output logic               pal_valid,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [VRAM_AW-1:0] mem_addr,
    output logic               mem_we,
    output logic [VRAM_DW-1:0] mem_wdata,
    input  logic [VRAM_DW-1:0] mem_rdata,
    output vram_state_e        dbg_state
);

    // Handshake: a requester holds req/addr until it samples ack high; ack is
    // combinational and coincides with the cycle mem_addr carries its address.
    logic               gnt_tile;
    logic               gnt_pal;
    logic               gnt_cpu;
    logic               cpu_we_en;
    logic               force_cpu;
    src_e               issue_src;
    src_e               ret_src;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_DW-1:0] wdata_q, wdata_d;
    logic [7:0]         tile_data_q;
    logic [5:0]         pal_data_q;

`ifdef VRAM_CPU_PORT_EN
    localparam int CW = $clog2(CPU_STARVE_MAX + 1);

    vram_state_e   state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;

    assign cpu_we_en = cpu_we;
    assign force_cpu = (state_q == ST_CPU_FORCE);
    assign dbg_state = state_q;

    // A withdrawn CPU request also restarts the wait count.
    always_comb begin
        starve_d = starve_q;
        state_d  = ST_NORMAL;
        if (!cpu_we || gnt_cpu) begin
            starve_d = '0;
        end else if (starve_q != CW'(CPU_STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
        end
        if ((state_q == ST_NORMAL) && (starve_d == CW'(CPU_STARVE_MAX))) begin
            state_d = ST_CPU_FORCE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
`else
    localparam int unused_starve_max = CPU_STARVE_MAX;
    logic unused_cpu_we;

    assign unused_cpu_we = cpu_we;
    assign cpu_we_en     = 1'b0;
    assign force_cpu     = 1'b0;
    assign dbg_state     = ST_NORMAL;
`endif

    always_comb begin
        gnt_tile = 1'b0;
        gnt_pal  = 1'b0;
        gnt_cpu  = 1'b0;
        if (rst) begin
            if (force_cpu && cpu_we_en) begin
                gnt_cpu = 1'b1;
            end else if (pal_req) begin
                gnt_pal = 1'b1;
            end else if (tile_req) begin
                gnt_tile = 1'b1;
            end else if (cpu_we_en) begin
                gnt_cpu = 1'b1;
            end
        end
    end

    // Bus address/data hold their last value on idle cycles.
    always_comb begin
        issue_src = SRC_NONE;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (gnt_pal) begin
            issue_src = SRC_PAL;
            addr_d    = palette_RAM_addr;
        end else if (gnt_tile) begin
            issue_src = SRC_TILE;
            addr_d    = tile_RAM_addr;
        end else if (gnt_cpu) begin
            issue_src = SRC_CPU;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
        end
    end

    vram_lat_pipe #(
        .DEPTH(MEM_LAT)
    ) u_lat_pipe (
        .clk  (clk),
        .rst  (rst),
        .tag_i(issue_src),
        .tag_o(ret_src)
    );

    assign tile_ack  = gnt_tile;
    assign pal_ack   = gnt_pal;
    assign cpu_ack   = gnt_cpu;
    assign mem_we    = gnt_cpu;
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;

    assign tile_valid       = (ret_src == SRC_TILE);
    assign pal_valid        = (ret_src == SRC_PAL);
    assign tile_ROM_addr    = tile_valid ? mem_rdata : tile_data_q;
    assign palette_ROM_addr = pal_valid ? mem_rdata[5:0] : pal_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            tile_data_q <= '0;
            pal_data_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tile_data_q <= tile_ROM_addr;
            pal_data_q  <= palette_ROM_addr;
        end
    end

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: MEM_LAT=1 and MEM_LAT=3 instances, scoreboard of returned reads.
// CPU-path scenarios follow VRAM_CPU_PORT_EN.
module tb_vram_responder;
    import video_pkg::*;

    typedef struct packed {
        src_e        src;
        logic [7:0]  data;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q1[$];
    exp_t exp_q3[$];
    logic [7:0] last_t [2];
    logic [5:0] last_p [2];

    logic [7:0] ram1 [0:65535];
    logic [7:0] ram3 [0:65535];

    logic        tr1 = 0, pr1 = 0, cw1 = 0;
    logic [15:0] ta1 = 0, pa1 = 0, ca1 = 0;
    logic [7:0]  cd1 = 0;
    logic        tk1, tv1, pk1, pv1, ck1, mw1;
    logic [7:0]  tro1, md1;
    logic [7:0]  mr1 = 0;
    logic [5:0]  pro1;
    logic [15:0] ma1;
    vram_state_e st1;

    logic        tr3 = 0, pr3 = 0, cw3 = 0;
    logic [15:0] ta3 = 0, pa3 = 0, ca3 = 0;
    logic [7:0]  cd3 = 0;
    logic        tk3, tv3, pk3, pv3, ck3, mw3;
    logic [7:0]  tro3, md3;
    logic [7:0]  mr3 = 0, r3a = 0, r3b = 0;
    logic [5:0]  pro3;
    logic [15:0] ma3;
    vram_state_e st3;

    vram_responder #(.MEM_LAT(1), .CPU_STARVE_MAX(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .tile_req(tr1), .tile_RAM_addr(ta1), .tile_ack(tk1), .tile_ROM_addr(tro1), .tile_valid(tv1),
        .pal_req(pr1), .palette_RAM_addr(pa1), .pal_ack(pk1), .palette_ROM_addr(pro1), .pal_valid(pv1),
        .cpu_we(cw1), .cpu_addr(ca1), .cpu_wdata(cd1), .cpu_ack(ck1),
        .mem_addr(ma1), .mem_we(mw1), .mem_wdata(md1), .mem_rdata(mr1), .dbg_state(st1)
    );

    vram_responder #(.MEM_LAT(3), .CPU_STARVE_MAX(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .tile_req(tr3), .tile_RAM_addr(ta3), .tile_ack(tk3), .tile_ROM_addr(tro3), .tile_valid(tv3),
        .pal_req(pr3), .palette_RAM_addr(pa3), .pal_ack(pk3), .palette_ROM_addr(pro3), .pal_valid(pv3),
        .cpu_we(cw3), .cpu_addr(ca3), .cpu_wdata(cd3), .cpu_ack(ck3),
        .mem_addr(ma3), .mem_we(mw3), .mem_wdata(md3), .mem_rdata(mr3), .dbg_state(st3)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM models ----------------
    always @(posedge clk) begin
        if (mw1) ram1[ma1] <= md1;
        mr1 <= ram1[ma1];
    end

    always @(posedge clk) begin
        r3a <= ram3[ma3];
        r3b <= r3a;
        mr3 <= r3b;
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input src_e s, input logic [7:0] data, input int lat);
        exp_t e;
        e.src  = s;
        e.data = data;
        e.due  = 32'(cyc + lat);
        if (k == 0) exp_q1.push_back(e);
        else exp_q3.push_back(e);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic mon(input int k, input logic tv, input logic [7:0] td, input logic pv, input logic [5:0] pd);
        exp_t e;
        logic have;
        have = 1'b0;
        e    = '0;
        if (k == 0 && exp_q1.size() > 0) begin e = exp_q1[0]; have = 1'b1; end
        if (k == 1 && exp_q3.size() > 0) begin e = exp_q3[0]; have = 1'b1; end
        chk($sformatf("d%0d tile/pal valid overlap", k), 32'(tv & pv), 0);
        if (!tv) chk($sformatf("d%0d tile data hold", k), 32'(td), 32'(last_t[k]));
        if (!pv) chk($sformatf("d%0d pal data hold", k), 32'(pd), 32'(last_p[k]));
        if (tv || pv) begin
            if (!have) begin
                chk($sformatf("d%0d valid with nothing expected", k), 32'({tv, pv}), 0);
            end else begin
                if (k == 0) void'(exp_q1.pop_front());
                else void'(exp_q3.pop_front());
                chk($sformatf("d%0d return source", k), 32'(tv ? SRC_TILE : SRC_PAL), 32'(e.src));
                chk($sformatf("d%0d return cycle", k), 32'(cyc), e.due);
                chk($sformatf("d%0d return data", k), tv ? 32'(td) : 32'(pd), 32'(e.data));
                if (e.src == SRC_TILE) last_t[k] = e.data;
                else last_p[k] = e.data[5:0];
            end
        end else if (have && e.due <= 32'(cyc)) begin
            chk($sformatf("d%0d expected valid missing", k), 32'(tv | pv), 1);
            if (k == 0) void'(exp_q1.pop_front());
            else void'(exp_q3.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q1.delete();
            exp_q3.delete();
            for (int i = 0; i < 2; i++) begin
                last_t[i] = 8'h00;
                last_p[i] = 6'h00;
            end
        end else begin
            mon(0, tv1, tro1, pv1, pro1);
            mon(1, tv3, tro3, pv3, pro3);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram1[i] = 8'h00;
            ram3[i] = 8'h00;
        end
        ram1[16'h0040] = 8'hA5;
        ram1[16'h0020] = 8'h5E;
        ram1[16'h0100] = 8'h2B;
        ram3[16'h0040] = 8'hA5;
        ram3[16'h0100] = 8'h2B;
        for (int i = 0; i < 2; i++) begin
            last_t[i] = 8'h00;
            last_p[i] = 6'h00;
        end

        // Reset with requests already pending: nothing may be granted.
        #2;
        rst = 1'b0;
        tr1 = 1; ta1 = 16'h0040; pr1 = 1; pa1 = 16'h0100; cw1 = 1; ca1 = 16'h0010; cd1 = 8'h3C;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst tile_ack", 32'(tk1), 0);
        chk("rst pal_ack", 32'(pk1), 0);
        chk("rst cpu_ack", 32'(ck1), 0);
        chk("rst mem_we", 32'(mw1), 0);
        chk("rst mem_addr", 32'(ma1), 0);
        chk("rst mem_wdata", 32'(md1), 0);
        chk("rst tile_valid", 32'(tv1), 0);
        chk("rst pal_valid", 32'(pv1), 0);
        chk("rst tile_ROM_addr", 32'(tro1), 0);
        chk("rst palette_ROM_addr", 32'(pro1), 0);
        chk("rst state", 32'(st1), 32'(ST_NORMAL));
        chk("rst d3 mem_addr", 32'(ma3), 0);

        // Release with a tile request waiting: granted in the first cycle.
        step();
        rst = 1'b1; pr1 = 0; cw1 = 0;
        @(negedge clk);
        chk("first tile_ack", 32'(tk1), 1);
        chk("first mem_addr", 32'(ma1), 'h0040);
        push(0, SRC_TILE, 8'hA5, 1);
        step();
        tr1 = 0;
        @(negedge clk);
        chk("idle tile_ack", 32'(tk1), 0);
        chk("idle mem_addr hold", 32'(ma1), 'h0040);
        chk("idle mem_we", 32'(mw1), 0);

        // Palette beats tile; tile served next cycle.
        step();
        pr1 = 1; pa1 = 16'h0100; tr1 = 1; ta1 = 16'h0020;
        @(negedge clk);
        chk("prio pal_ack", 32'(pk1), 1);
        chk("prio tile_ack", 32'(tk1), 0);
        chk("prio mem_addr pal", 32'(ma1), 'h0100);
        push(0, SRC_PAL, 8'h2B, 1);
        step();
        pr1 = 0;
        @(negedge clk);
        chk("prio tile_ack c1", 32'(tk1), 1);
        chk("prio pal_ack c1", 32'(pk1), 0);
        chk("prio mem_addr tile", 32'(ma1), 'h0020);
        push(0, SRC_TILE, 8'h5E, 1);
        step();
        tr1 = 0;

        // Tile withdraws while losing to palette: no ack, no data.
        step();
        pr1 = 1; tr1 = 1; ta1 = 16'h0040;
        @(negedge clk);
        chk("withdraw tile_ack c0", 32'(tk1), 0);
        push(0, SRC_PAL, 8'h2B, 1);
        step();
        pr1 = 0; tr1 = 0;
        @(negedge clk);
        chk("withdraw tile_ack c1", 32'(tk1), 0);
        chk("withdraw mem_addr hold", 32'(ma1), 'h0100);

        // Back-to-back tile reads.
        step();
        tr1 = 1; ta1 = 16'h0040;
        @(negedge clk);
        chk("b2b ack0", 32'(tk1), 1);
        push(0, SRC_TILE, 8'hA5, 1);
        step();
        ta1 = 16'h0020;
        @(negedge clk);
        chk("b2b ack1", 32'(tk1), 1);
        chk("b2b mem_addr1", 32'(ma1), 'h0020);
        push(0, SRC_TILE, 8'h5E, 1);
        step();
        tr1 = 0;

`ifdef VRAM_CPU_PORT_EN
        // Uncontended CPU write is granted immediately.
        step();
        cw1 = 1; ca1 = 16'h0011; cd1 = 8'h77;
        @(negedge clk);
        chk("cpu solo ack", 32'(ck1), 1);
        chk("cpu solo mem_we", 32'(mw1), 1);
        chk("cpu solo mem_addr", 32'(ma1), 'h0011);
        chk("cpu solo mem_wdata", 32'(md1), 'h77);
        step();
        cw1 = 0;

        // CPU starved by a continuous palette stream is forced at wait cycle 8.
        pr1 = 1; pa1 = 16'h0100; cw1 = 1; ca1 = 16'h0010; cd1 = 8'h3C;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("starve cpu_ack w%0d", k), 32'(ck1), 0);
                chk($sformatf("starve mem_we w%0d", k), 32'(mw1), 0);
                chk($sformatf("starve pal_ack w%0d", k), 32'(pk1), 1);
                chk($sformatf("starve state w%0d", k), 32'(st1), 32'(ST_NORMAL));
                push(0, SRC_PAL, 8'h2B, 1);
            end else begin
                chk("force cpu_ack", 32'(ck1), 1);
                chk("force mem_we", 32'(mw1), 1);
                chk("force mem_addr", 32'(ma1), 'h0010);
                chk("force mem_wdata", 32'(md1), 'h3C);
                chk("force pal_ack", 32'(pk1), 0);
                chk("force state", 32'(st1), 32'(ST_CPU_FORCE));
            end
            step();
        end
        cw1 = 0;
        @(negedge clk);
        chk("after force pal_ack", 32'(pk1), 1);
        chk("after force state", 32'(st1), 32'(ST_NORMAL));
        push(0, SRC_PAL, 8'h2B, 1);
        step();
        pr1 = 0;
        tr1 = 1; ta1 = 16'h0010;
        @(negedge clk);
        chk("readback tile_ack", 32'(tk1), 1);
        push(0, SRC_TILE, 8'h3C, 1);
        step();
        tr1 = 0;
`else
        // CPU port compiled out: a held write is never acknowledged.
        step();
        cw1 = 1; ca1 = 16'h0010; cd1 = 8'h3C; ta1 = 16'h0040; pa1 = 16'h0100;
        for (int k = 0; k < 20; k++) begin
            tr1 = (k % 3 == 0);
            pr1 = (k % 3 == 1);
            @(negedge clk);
            chk($sformatf("nocpu cpu_ack c%0d", k), 32'(ck1), 0);
            chk($sformatf("nocpu mem_we c%0d", k), 32'(mw1), 0);
            chk($sformatf("nocpu tile_ack c%0d", k), 32'(tk1), 32'(k % 3 == 0));
            chk($sformatf("nocpu pal_ack c%0d", k), 32'(pk1), 32'(k % 3 == 1));
            if (k % 3 == 0) push(0, SRC_TILE, 8'hA5, 1);
            if (k % 3 == 1) push(0, SRC_PAL, 8'h2B, 1);
            step();
        end
        cw1 = 0; tr1 = 0; pr1 = 0;
`endif

        // MEM_LAT=3 instance: plain read latency.
        step();
        tr3 = 1; ta3 = 16'h0040;
        @(negedge clk);
        chk("d3 tile_ack", 32'(tk3), 1);
        push(1, SRC_TILE, 8'hA5, 3);
        step();
        tr3 = 0;
        repeat (4) step();

        // Two reads in flight, then a one-cycle reset: nothing may return.
        tr3 = 1; ta3 = 16'h0040;
        @(negedge clk);
        chk("d3 inflight tile_ack", 32'(tk3), 1);
        push(1, SRC_TILE, 8'hA5, 3);
        step();
        tr3 = 0; pr3 = 1; pa3 = 16'h0100;
        @(negedge clk);
        chk("d3 inflight pal_ack", 32'(pk3), 1);
        push(1, SRC_PAL, 8'h2B, 3);
        step();
        pr3 = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("d3 rst tile_valid", 32'(tv3), 0);
        chk("d3 rst pal_valid", 32'(pv3), 0);
        chk("d3 rst tile_ROM_addr", 32'(tro3), 0);
        chk("d3 rst palette_ROM_addr", 32'(pro3), 0);
        chk("d3 rst mem_addr", 32'(ma3), 0);
        chk("d3 rst acks", 32'({tk3, pk3, ck3, mw3}), 0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("d3 flushed valid c%0d", k), 32'({tv3, pv3}), 0);
        end

        repeat (3) step();
        chk("d1 scoreboard drained", 32'(exp_q1.size()), 0);
        chk("d3 scoreboard drained", 32'(exp_q3.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: bench did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
